bshaper_multi: RTL and testbench
================================

# bshaper_multi

Parametrised multi-channel successor to the single-button shaper. Each of N channels synchronises a raw push-button input, debounces it over a programmable number of clock cycles, and emits exactly one single-cycle pulse per debounced press. With the repeat feature compiled in, a button that stays held also produces additional pulses at a fixed rate. The block sits between the board push-buttons and any control logic that consumes one-cycle button events.

## Interface
- N, 4: number of independent button channels (≥1).
- DB_CYCLES, 16: debounce length in clock cycles (≥1).
- ACTIVE_LOW, 1: 1 means a raw input of 0 is "pressed"; 0 means a raw input of 1 is "pressed".
- REPEAT_DELAY, 1000: cycles from the first pulse to the first repeat pulse (≥2). Used only with BSHAPER_REPEAT_EN.
- REPEAT_PERIOD, 250: cycles between later repeat pulses (≥2). Used only with BSHAPER_REPEAT_EN.
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- button_in  input  N  raw, asynchronous button levels; polarity set by ACTIVE_LOW.
- button_out  output  N  registered pulse per channel, active-high, one cycle wide.

## Operation
- Channels are fully independent. Each channel has a 2-flop synchroniser, a debounce counter of width $clog2(DB_CYCLES+1), and a state register. With the repeat feature compiled in, each channel also has a repeat timer.
- Synchroniser flops reset to the released level: 1 when ACTIVE_LOW=1, 0 when ACTIVE_LOW=0.
- p is the synchronised "pressed" condition after polarity correction.
- Per-channel states and transitions:
  - IDLE: button_out=0. If p, go to PRESS_WAIT and load the counter.
  - PRESS_WAIT: if !p, return to IDLE (glitch rejected). Once p has been seen for DB_CYCLES consecutive cycles, go to PULSE.
  - PULSE: button_out=1 for exactly this one cycle; then go to HELD. The repeat timer clears.
  - HELD: button_out=0. If !p, go to REL_WAIT and load the counter. With repeat compiled in, go to PULSE when the timer reaches REPEAT_DELAY (first repeat) or REPEAT_PERIOD (every later repeat).
  - REL_WAIT: if p, return to HELD; the repeat timer restarts from 0 and stays in its current phase (delay or period). Once !p has been seen for DB_CYCLES consecutive cycles, go to IDLE.
- A press produces no second pulse until a release has been fully debounced, except for repeat pulses.
- Counters saturate and never wrap.
- Reset at any time, including mid-debounce or mid-pulse:
  - all states go to IDLE;
  - all outputs and counters go to 0;
  - synchronisers go to the released level.
- If a button is held across reset release, it yields one normal pulse with the normal latency measured from reset release.

## Timing
- Reset value: button_out = {N{1'b0}}.
- Press latency: let edge k be the first rising edge that samples the pressed level. If the press is held, button_out rises at edge k+DB_CYCLES+2 (2 synchroniser edges plus DB_CYCLES debounce edges) and falls at the next edge.
- Press shorter than DB_CYCLES cycles (after synchronisation): no pulse.
- Release latency: the channel returns to IDLE DB_CYCLES+2 edges after the first sampled released level. A new press is accepted from that point on.
- Repeat (compiled in): with the first pulse at edge P, repeat pulses occur at edges P+REPEAT_DELAY, then P+REPEAT_DELAY+n·REPEAT_PERIOD for n≥1.
- Simultaneous presses on several channels produce simultaneous pulses. There is no arbitration.

## Configuration
- BSHAPER_REPEAT_EN
  - Defined: repeat timers and HELD→PULSE transitions are implemented as described above.
  - Undefined: no repeat timers are synthesised. REPEAT_DELAY and REPEAT_PERIOD are ignored. Exactly one pulse is produced per debounced press.

## Test plan
All scenarios use N=2, DB_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset: RST=0 with button_in=2'b00 for 3 cycles → button_out=2'b00 throughout. After RST=1, channel 0 held low pulses at edge 6 after release (4+2).
- Clean press: ch0 low from edge k, held 20 cycles → single pulse at edge k+6, exactly one cycle wide. Ch1 stays 0.
- Glitch rejection: ch0 low for 3 cycles then high → no pulse. Release bounce of 2 cycles low during REL_WAIT → no pulse.
- Independence: ch0 pressed at edge 10 and ch1 at edge 12 → pulses at edges 16 and 18. Both pressed together → button_out=2'b11 for one cycle.
- Reset mid-operation: RST=0 during PRESS_WAIT and again during PULSE → output drops to 0 immediately, and no pulse fires without a fresh debounce after release.
- Repeat (BSHAPER_REPEAT_EN): ch0 held 30 cycles with first pulse at P → pulses at P, P+8, P+11, P+14, … until release. With the macro undefined, only the pulse at P occurs.

Source files
------------

// File: rtl/bshaper_multi.sv
// N-channel push-button shaper: 2-flop sync, debounce, one-cycle pulse per press.
// Define BSHAPER_REPEAT_EN to add auto-repeat pulses while a button stays held.
module bshaper_multi #(
  parameter int N             = 4,
  parameter int DB_CYCLES     = 16,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 250
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] button_in,
  output logic [N-1:0] button_out
);

  localparam int            CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic          REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_PULSE,
    S_HELD,
    S_REL_WAIT
  } state_t;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_out;
    logic          w_p;

    // Synchroniser idles at the released level so reset never looks like a press.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_sync1 <= REL_LVL;
        r_sync2 <= REL_LVL;
      end else begin
        r_sync1 <= button_in[g];
        r_sync2 <= r_sync1;
      end
    end

    assign w_p = r_sync2 ^ REL_LVL;

`ifdef BSHAPER_REPEAT_EN
    localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            TW   = $clog2(RMAX + 1);
    logic [TW-1:0] r_tmr;
    logic          r_phase;
    logic [TW-1:0] w_tmr_last;

    // r_tmr counts edges since the last pulse edge; r_phase=1 once the first repeat fired.
    assign w_tmr_last = r_phase ? TW'(REPEAT_PERIOD - 1) : TW'(REPEAT_DELAY - 1);
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and the per-channel blocks cannot race.
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
`ifdef BSHAPER_REPEAT_EN
        r_tmr   <= '0;
        r_phase <= 1'b0;
`endif
      end else begin
        r_out <= 1'b0;
        case (r_state)
          S_IDLE: begin
            if (w_p) begin
              r_state <= S_PRESS_WAIT;
              r_cnt   <= '0;
            end
          end
          S_PRESS_WAIT: begin
            if (!w_p) begin
              r_state <= S_IDLE;
            end else if (r_cnt == DB_LAST) begin
              r_state <= S_PULSE;
              r_out   <= 1'b1;
`ifdef BSHAPER_REPEAT_EN
              r_tmr   <= '0;
              r_phase <= 1'b0;
`endif
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_PULSE: begin
            r_state <= S_HELD;
`ifdef BSHAPER_REPEAT_EN
            r_tmr   <= r_tmr + TW'(1);
`endif
          end
          S_HELD: begin
            if (!w_p) begin
              r_state <= S_REL_WAIT;
              r_cnt   <= '0;
`ifdef BSHAPER_REPEAT_EN
            end else if (r_tmr == w_tmr_last) begin
              r_state <= S_PULSE;
              r_out   <= 1'b1;
              r_tmr   <= '0;
              r_phase <= 1'b1;
            end else begin
              r_tmr <= r_tmr + TW'(1);
`endif
            end
          end
          S_REL_WAIT: begin
            if (w_p) begin
              r_state <= S_HELD;
`ifdef BSHAPER_REPEAT_EN
              r_tmr   <= '0;
`endif
            end else if (r_cnt == DB_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end

    assign button_out[g] = r_out;
  end

endmodule

// File: tb/tb_bshaper_multi.sv
// Table-driven bench for bshaper_multi (N=2, DB=4, active-low, repeat 8/3),
// plus hand-written sequences for reset in the middle of a pulse.
module tb_bshaper_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] button_in;
  logic [1:0] button_out;

  bshaper_multi #(
    .N            (2),
    .DB_CYCLES    (4),
    .ACTIVE_LOW   (1),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .button_in (button_in),
    .button_out(button_out)
  );

  always #5 CLK = ~CLK;

  // One record per clock edge: inputs held across edge i, output expected after it.
  typedef struct {
    logic       rst;
    logic [1:0] btn;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic int add(input logic rst, input logic [1:0] btn, input int n);
    int s;
    vec_t v;
    s = vecs.size();
    v.rst = rst;
    v.btn = btn;
    v.exp = 2'b00;
    for (int i = 0; i < n; i++) vecs.push_back(v);
    return s;
  endfunction

  function automatic void mark(input int idx, input logic [1:0] val);
    vec_t v;
    v = vecs[idx];
    v.exp = val;
    vecs[idx] = v;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: button_out=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    int s;
    RST       = 1'b0;
    button_in = 2'b11;

    // Reset with both buttons pressed: output stays 0.
    void'(add(1'b0, 2'b00, 3));
    // Ch0 held across reset release: first sampling edge is k=s, pulse at k+6.
    s = add(1'b1, 2'b10, 12);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);

    // Clean press held 20 cycles.
    s = add(1'b1, 2'b10, 20);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);
`ifdef BSHAPER_REPEAT_EN
    mark(s + 14, 2'b01);
    mark(s + 17, 2'b01);
    mark(s + 20, 2'b01);
`endif

    // 3-cycle glitch: rejected.
    void'(add(1'b1, 2'b10, 3));
    void'(add(1'b1, 2'b11, 8));

    // Shortest press that still pulses: pressed level sampled at k..k+4.
    s = add(1'b1, 2'b10, 5);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);

    // Press, then a 2-cycle bounce low during release debounce: single pulse only.
    s = add(1'b1, 2'b10, 10);
    void'(add(1'b1, 2'b11, 3));
    void'(add(1'b1, 2'b10, 2));
    void'(add(1'b1, 2'b11, 12));
    mark(s + 6, 2'b01);

    // Independent channels: ch0 at s, ch1 at s+2.
    s = add(1'b1, 2'b10, 2);
    void'(add(1'b1, 2'b00, 10));
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);
    mark(s + 8, 2'b10);

    // Simultaneous press on both channels.
    s = add(1'b1, 2'b00, 10);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b11);

    // Reset during PRESS_WAIT, button kept low: fresh debounce from release.
    void'(add(1'b1, 2'b10, 4));
    void'(add(1'b0, 2'b10, 2));
    s = add(1'b1, 2'b10, 10);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);

    // Long hold of 30 cycles.
    s = add(1'b1, 2'b10, 30);
    void'(add(1'b1, 2'b11, 10));
    mark(s + 6, 2'b01);
`ifdef BSHAPER_REPEAT_EN
    for (int e = s + 14; e <= s + 29; e += 3) mark(e, 2'b01);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST       = vecs[i].rst;
      button_in = vecs[i].btn;
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d", i), button_out, vecs[i].exp);
    end

    // Reset asserted while the pulse is high.
    @(negedge CLK);
    button_in = 2'b10;
    repeat (7) @(posedge CLK);
    #1;
    check("pulse_before_reset", button_out, 2'b01);
    RST = 1'b0;
    #1;
    check("reset_mid_pulse", button_out, 2'b00);
    for (int j = 0; j < 3; j++) begin
      @(posedge CLK);
      #1;
      check("held_in_reset", button_out, 2'b00);
    end

    // Released on reset exit: no leftover pulse.
    @(negedge CLK);
    RST       = 1'b1;
    button_in = 2'b11;
    for (int j = 0; j < 12; j++) begin
      @(posedge CLK);
      #1;
      check($sformatf("quiet_after_reset_%0d", j), button_out, 2'b00);
    end

    // Fresh press after reset pulses with normal latency.
    @(negedge CLK);
    button_in = 2'b10;
    for (int j = 1; j <= 10; j++) begin
      @(posedge CLK);
      #1;
      check($sformatf("fresh_press_e%0d", j), button_out, (j == 7) ? 2'b01 : 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
